noc_input_buffer: RTL and testbench
===================================

Name: noc_input_buffer

Overview:
- Per-direction input stage of the router. One instance each for L, N, E, W and S.
- Buffers incoming flits in a FIFO and decodes packet framing.
- Drives the req, flit_id and length inputs of the router arbiter.
- Releases flits downstream only while the arbiter grants this direction.

Parameters:
- DATA_WIDTH, 32: flit width. Bits [DATA_WIDTH-1:DATA_WIDTH-3] hold the flit id; bits [11:0] of a header hold the packet length. Minimum 16.
- DEPTH, 4: FIFO entries. Power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- in_data  in  DATA_WIDTH  incoming flit
- in_valid  in  1  in_data valid
- in_ready  out  1  buffer can accept; equals not full
- grant  in  1  this direction's one-hot bit of the arbiter state
- out_data  out  DATA_WIDTH  head flit
- out_valid  out  1  head flit valid; equals not empty
- flit_id  out  3  id of head flit; 3'b000 when empty
- length  out  12  packet length for the arbiter timer
- req  out  1  request to arbiter
- count  out  log2(DEPTH)+1  occupancy
- err  out  1  sticky framing error

Behaviour:
- Reset (rst==0 at a clk edge):
  - Pointers and count cleared; state=IDLE; err=0; length register=0.
  - Resulting outputs: in_ready=1, out_valid=0, flit_id=0, req=0.
  - Reset mid-packet discards all stored flits. in_valid is ignored during the reset cycle.
- Flit ids: 3'b001 header, 3'b010 body, 3'b100 tail. Any other id is treated as body.
- FIFO:
  - push = in_valid && in_ready.
  - pop = out_valid && (grant || drop).
  - Push and pop in the same cycle leave count unchanged. Push when full is impossible because in_ready=0.
  - No bypass: a flit pushed at edge N is at the head (out_valid=1) after edge N, never combinationally in the same cycle.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- out_data: the head entry, combinational from storage. Don't-care when empty.
- length:
  - When the head flit is a header: head[11:0], combinational.
  - Otherwise: the length register, which loads head[11:0] whenever a header is popped.
- State machine states: IDLE (no packet in flight) and ACTIVE (header forwarded, tail pending).
- IDLE:
  - req = out_valid && head is header.
  - Head is body or tail: drop=1. The flit is popped without grant and err is set.
  - Header popped (grant): go to ACTIVE.
  - If the header itself is also a tail (length==0 convention not used), it still goes to ACTIVE.
- ACTIVE:
  - req=1 regardless of empty, so the arbiter does not lose the packet on FIFO underrun.
  - Tail popped under grant: go to IDLE. req is recomputed combinationally from the next head in the next cycle.
  - Head is header (missing tail): set err, go to IDLE without popping, so the header re-arbitrates.
- grant while out_valid=0: no effect.
- grant deasserted mid-packet (arbiter timeout): state stays ACTIVE, req stays 1, no pops.
- Simultaneous tail pop and push of a new header: both take effect. Next cycle state=IDLE and the header is visible once it is at the head.
- err: cleared only by reset.

Test Plan:
- Reset with in_valid=1, in_data=header → after release: count=0, req=0, in_ready=1, flit_id=0, err=0.
- Push header (id 001, len 12'h005), body, tail; grant=0 → count=3, req=1, flit_id=001, length=5. Assert grant for 3 cycles → out_data sequence header/body/tail, state back to IDLE, req=0, count=0.
- DEPTH=4, push 5 flits with grant=0 → in_ready=0 after the 4th, 5th not accepted, count=4. Push and pop in the same cycle at count=3 → count stays 3.
- Packet in ACTIVE with FIFO emptied (header and body popped, tail not yet arrived) → req=1, out_valid=0. Tail arrives → popped on next grant, req drops.
- Body flit at head in IDLE with grant=0 → popped next cycle, err=1, req stays 0. Header arriving after the error → req=1.
- Header, body, then second header with no tail, grant=1 → after body: err=1, state IDLE, second header not popped that cycle, req=1, length = second header's value.

Source files
------------

// File: rtl/noc_input_buffer.sv
// Per-direction router input stage: flit FIFO plus packet-framing FSM that
// drives the arbiter's req/flit_id/length and drops orphan body/tail flits.
module noc_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     grant,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  output logic [2:0]               flit_id,
  output logic [11:0]              length,
  output logic                     req,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] ID_HDR  = 3'b001;
  localparam logic [2:0] ID_TAIL = 3'b100;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic [11:0]           len_q;
  state_t                state, state_nx;
  logic                  push, pop, err_set, len_load;
  logic [2:0]            head_id;
  logic                  is_hdr, is_tail;

  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign count     = cnt;
  assign out_data  = mem[rd_ptr];
  assign head_id   = out_data[DATA_WIDTH-1:DATA_WIDTH-3];
  assign is_hdr    = out_valid && (head_id == ID_HDR);
  assign is_tail   = out_valid && (head_id == ID_TAIL);
  assign flit_id   = out_valid ? head_id : 3'b000;
  assign length    = is_hdr ? out_data[11:0] : len_q;
  assign push      = in_valid && in_ready;

  // Framing FSM: IDLE drops anything that is not a header; ACTIVE aborts on a
  // new header so it can re-arbitrate without being consumed.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    err_set  = 1'b0;
    len_load = 1'b0;
    req      = 1'b0;
    case (state)
      IDLE: begin
        req = is_hdr;
        if (out_valid) begin
          if (!is_hdr) begin
            pop     = 1'b1;
            err_set = 1'b1;
          end else if (grant) begin
            pop      = 1'b1;
            len_load = 1'b1;
            state_nx = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        req = 1'b1;
        if (is_hdr) begin
          err_set  = 1'b1;
          state_nx = IDLE;
        end else if (out_valid && grant) begin
          pop = 1'b1;
          if (is_tail) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      err   <= 1'b0;
      len_q <= '0;
    end else begin
      state <= state_nx;
      if (err_set)  err   <= 1'b1;
      if (len_load) len_q <= out_data[11:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_noc_input_buffer.sv
// Bench for noc_input_buffer: directed table, corner sequences, and random
// traffic checked against a queue-based packet model.
module tb_noc_input_buffer;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          grant;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [2:0]    flit_id;
  logic [11:0]   length;
  logic          req;
  logic [2:0]    count;
  logic          err;

  noc_input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .grant(grant), .out_data(out_data),
    .out_valid(out_valid), .flit_id(flit_id), .length(length), .req(req),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a queue of flits plus "packet in flight" flag.
  logic [DW-1:0] mq[$];
  bit            m_act;
  bit            m_err;
  logic [11:0]   m_len;

  localparam logic [DW-1:0] HDR5  = 32'h2000_0005;
  localparam logic [DW-1:0] BODY  = 32'h4000_00AB;
  localparam logic [DW-1:0] TAIL  = 32'h8000_00CD;
  localparam logic [DW-1:0] HDR7  = 32'h2000_0007;
  localparam logic [DW-1:0] HDR9  = 32'h2000_0009;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit iv, input logic [DW-1:0] d, input bit g);
    int sz;
    bit pop_m, push_m;
    logic [DW-1:0] h;
    logic [2:0] id;
    if (!r) begin
      mq.delete();
      m_act = 0;
      m_err = 0;
      m_len = '0;
      return;
    end
    sz = mq.size();
    push_m = iv && (sz < DEPTH);
    pop_m = 0;
    if (sz > 0) begin
      h = mq[0];
      id = h[DW-1:DW-3];
      if (!m_act) begin
        if (id != 3'b001) begin
          pop_m = 1;
          m_err = 1;
        end else if (g) begin
          pop_m = 1;
          m_act = 1;
          m_len = h[11:0];
        end
      end else begin
        if (id == 3'b001) begin
          m_err = 1;
          m_act = 0;
        end else if (g) begin
          pop_m = 1;
          if (id == 3'b100) m_act = 0;
        end
      end
    end
    if (pop_m) void'(mq.pop_front());
    if (push_m) mq.push_back(d);
  endtask

  task automatic model_check();
    int sz;
    bit hh;
    logic [DW-1:0] h;
    sz = mq.size();
    h = (sz > 0) ? mq[0] : '0;
    hh = (sz > 0) && (h[DW-1:DW-3] == 3'b001);
    chk("mdl_count", int'(count), sz);
    chk("mdl_in_ready", int'(in_ready), int'(sz < DEPTH));
    chk("mdl_out_valid", int'(out_valid), int'(sz > 0));
    chk("mdl_flit_id", int'(flit_id), (sz > 0) ? int'(h[DW-1:DW-3]) : 0);
    chk("mdl_req", int'(req), int'(m_act || hh));
    chk("mdl_length", int'(length), hh ? int'(h[11:0]) : int'(m_len));
    chk("mdl_err", int'(err), int'(m_err));
    if (sz > 0) chk("mdl_out_data", int'(out_data), int'(h));
  endtask

  task automatic step(input bit r, input bit iv, input logic [DW-1:0] d, input bit g);
    rst = r; in_valid = iv; in_data = d; grant = g;
    model_edge(r, iv, d, g);
    @(posedge clk);
    #1;
    model_check();
  endtask

  typedef struct {
    bit r; bit iv; logic [DW-1:0] d; bit g;
    int cnt; bit rq; logic [2:0] fid; logic [11:0] len; bit er; bit rdy;
    logic [DW-1:0] dat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; grant = 1'b0;
    tbl[0] = '{0, 1, HDR5, 0, 0, 0, 3'b000, 12'h000, 0, 1, '0};
    tbl[1] = '{1, 1, HDR5, 0, 1, 1, 3'b001, 12'h005, 0, 1, HDR5};
    tbl[2] = '{1, 1, BODY, 0, 2, 1, 3'b001, 12'h005, 0, 1, HDR5};
    tbl[3] = '{1, 1, TAIL, 0, 3, 1, 3'b001, 12'h005, 0, 1, HDR5};
    tbl[4] = '{1, 0, '0,   1, 2, 1, 3'b010, 12'h005, 0, 1, BODY};
    tbl[5] = '{1, 0, '0,   1, 1, 1, 3'b100, 12'h005, 0, 1, TAIL};
    tbl[6] = '{1, 0, '0,   1, 0, 0, 3'b000, 12'h005, 0, 1, '0};
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].g);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d_req", i), int'(req), int'(tbl[i].rq));
      chk($sformatf("tbl%0d_flit_id", i), int'(flit_id), int'(tbl[i].fid));
      chk($sformatf("tbl%0d_length", i), int'(length), int'(tbl[i].len));
      chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].er));
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].rdy));
      if (tbl[i].cnt != 0) chk($sformatf("tbl%0d_out_data", i), int'(out_data), int'(tbl[i].dat));
    end

    // Fill to full, push+pop at count 3, then underrun in ACTIVE.
    step(0, 0, '0, 0);
    step(1, 1, HDR5, 0);
    step(1, 1, BODY, 0);
    step(1, 1, BODY, 0);
    step(1, 1, BODY, 0);
    chk("full_count", int'(count), 4);
    chk("full_in_ready", int'(in_ready), 0);
    step(1, 1, BODY, 0);
    chk("full_reject_count", int'(count), 4);
    step(1, 0, '0, 1);
    chk("pop_hdr_count", int'(count), 3);
    step(1, 1, BODY, 1);
    chk("pushpop_count", int'(count), 3);
    step(1, 0, '0, 1);
    step(1, 0, '0, 1);
    step(1, 0, '0, 1);
    chk("underrun_count", int'(count), 0);
    chk("underrun_req", int'(req), 1);
    chk("underrun_out_valid", int'(out_valid), 0);
    step(1, 1, TAIL, 0);
    chk("tail_arrive_req", int'(req), 1);
    step(1, 0, '0, 1);
    chk("tail_pop_req", int'(req), 0);
    chk("tail_pop_count", int'(count), 0);

    // Orphan body in IDLE is dropped without grant.
    step(0, 0, '0, 0);
    step(1, 1, BODY, 0);
    chk("orphan_req", int'(req), 0);
    chk("orphan_err_pre", int'(err), 0);
    step(1, 0, '0, 0);
    chk("orphan_err", int'(err), 1);
    chk("orphan_count", int'(count), 0);
    chk("orphan_req_after", int'(req), 0);
    step(1, 1, HDR5, 0);
    chk("hdr_after_err_req", int'(req), 1);

    // Missing tail: second header aborts the first packet without being popped.
    step(0, 0, '0, 0);
    step(1, 1, HDR7, 0);
    step(1, 1, BODY, 0);
    step(1, 1, HDR9, 0);
    step(1, 0, '0, 1);
    step(1, 0, '0, 1);
    chk("abort_pre_err", int'(err), 0);
    step(1, 0, '0, 0);
    chk("abort_err", int'(err), 1);
    chk("abort_count", int'(count), 1);
    chk("abort_req", int'(req), 1);
    chk("abort_length", int'(length), 12'h009);
    chk("abort_flit_id", int'(flit_id), 3'b001);

    // Random traffic against the model.
    step(0, 0, '0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [2:0] id;
      logic [DW-1:0] d;
      case ($urandom_range(0, 5))
        0, 1:    id = 3'b001;
        2, 3:    id = 3'b010;
        4:       id = 3'b100;
        default: id = 3'($urandom_range(0, 7));
      endcase
      d = {id, 29'($urandom)};
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 2) != 0), d,
           ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
